// File: rtl/xbar_bridge_slave_port.sv
// Slave-side crossbar endpoint: forwards requests to an in-order target and re-tags responses with ID/AUX.
// Define XBRIDGE_SLV_RSP_REG_EN to register the response outputs (+1 cycle latency).
module xbar_bridge_slave_port #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int BE_WIDTH        = DATA_WIDTH/8,
   parameter int ID_WIDTH        = 9,
   parameter int AUX_WIDTH       = 8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 data_req_i,
   input  logic [ADDR_WIDTH-1:0]                data_add_i,
   input  logic                                 data_wen_i,
   input  logic [DATA_WIDTH-1:0]                data_wdata_i,
   input  logic [BE_WIDTH-1:0]                  data_be_i,
   input  logic [ID_WIDTH-1:0]                  data_ID_i,
   input  logic [AUX_WIDTH-1:0]                 data_aux_i,
   output logic                                 data_gnt_o,
   output logic                                 data_r_valid_o,
   output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
   output logic [ID_WIDTH-1:0]                  data_r_ID_o,
   output logic                                 data_r_opc_o,
   output logic [AUX_WIDTH-1:0]                 data_r_aux_o,
   output logic                                 tgt_req_o,
   output logic [ADDR_WIDTH-1:0]                tgt_add_o,
   output logic                                 tgt_wen_o,
   output logic [DATA_WIDTH-1:0]                tgt_wdata_o,
   output logic [BE_WIDTH-1:0]                  tgt_be_o,
   input  logic                                 tgt_gnt_i,
   input  logic                                 tgt_r_valid_i,
   input  logic [DATA_WIDTH-1:0]                tgt_r_rdata_i,
   input  logic                                 tgt_r_opc_i,
   output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
   output logic                                 spurious_rsp_o
);

   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;

   logic [ID_WIDTH-1:0]   id_mem  [MAX_OUTSTANDING];
   logic [AUX_WIDTH-1:0]  aux_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      cnt;
   logic                  full, empty, push, pop;

   logic                  rsp_vld_p0;
   logic [DATA_WIDTH-1:0] rsp_rdata_p0;
   logic [ID_WIDTH-1:0]   rsp_id_p0;
   logic [AUX_WIDTH-1:0]  rsp_aux_p0;
   logic                  rsp_opc_p0;
   logic                  spur_p0;

   // full ignores a same-cycle pop so the grant never depends on tgt_r_valid_i
   assign full  = (cnt == CNT_W'(MAX_OUTSTANDING));
   assign empty = (cnt == '0);

   assign tgt_req_o   = data_req_i & ~full;
   assign data_gnt_o  = data_req_i & tgt_gnt_i & ~full;
   assign tgt_add_o   = data_add_i;
   assign tgt_wen_o   = data_wen_i;
   assign tgt_wdata_o = data_wdata_i;
   assign tgt_be_o    = data_be_i;

   assign push = data_req_i & data_gnt_o;
   assign pop  = tgt_r_valid_i & ~empty;
   assign outstanding_o = cnt;

   always_ff @(posedge clk) begin
      if (push) begin
         id_mem[wr_ptr]  <= data_ID_i;
         aux_mem[wr_ptr] <= data_aux_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Stage p0: response re-tagging, payload forced to zero when idle
   always_comb begin
      rsp_vld_p0   = pop;
      rsp_rdata_p0 = '0;
      rsp_id_p0    = '0;
      rsp_aux_p0   = '0;
      rsp_opc_p0   = 1'b0;
      if (pop) begin
         rsp_rdata_p0 = tgt_r_rdata_i;
         rsp_id_p0    = id_mem[rd_ptr];
         rsp_aux_p0   = aux_mem[rd_ptr];
         rsp_opc_p0   = tgt_r_opc_i;
      end
   end

   assign spur_p0 = tgt_r_valid_i & empty;

`ifdef XBRIDGE_SLV_RSP_REG_EN
   logic                  rsp_vld_p1;
   logic [DATA_WIDTH-1:0] rsp_rdata_p1;
   logic [ID_WIDTH-1:0]   rsp_id_p1;
   logic [AUX_WIDTH-1:0]  rsp_aux_p1;
   logic                  rsp_opc_p1;
   logic                  spur_p1;

   // Stage p1: registered response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_vld_p1   <= 1'b0;
         rsp_rdata_p1 <= '0;
         rsp_id_p1    <= '0;
         rsp_aux_p1   <= '0;
         rsp_opc_p1   <= 1'b0;
         spur_p1      <= 1'b0;
      end else begin
         rsp_vld_p1   <= rsp_vld_p0;
         rsp_rdata_p1 <= rsp_rdata_p0;
         rsp_id_p1    <= rsp_id_p0;
         rsp_aux_p1   <= rsp_aux_p0;
         rsp_opc_p1   <= rsp_opc_p0;
         spur_p1      <= spur_p0;
      end
   end

   assign data_r_valid_o = rsp_vld_p1;
   assign data_r_rdata_o = rsp_rdata_p1;
   assign data_r_ID_o    = rsp_id_p1;
   assign data_r_aux_o   = rsp_aux_p1;
   assign data_r_opc_o   = rsp_opc_p1;
   assign spurious_rsp_o = spur_p1;
`else
   assign data_r_valid_o = rsp_vld_p0;
   assign data_r_rdata_o = rsp_rdata_p0;
   assign data_r_ID_o    = rsp_id_p0;
   assign data_r_aux_o   = rsp_aux_p0;
   assign data_r_opc_o   = rsp_opc_p0;
   assign spurious_rsp_o = spur_p0;
`endif

endmodule

// File: tb/tb_xbar_bridge_slave_port.sv
// Bench for xbar_bridge_slave_port: queue-based reference model plus directed scenarios.
// Honours XBRIDGE_SLV_RSP_REG_EN for the registered-response build.
module tb_xbar_bridge_slave_port;

   localparam int MAXO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_req_i;
   logic [31:0] data_add_i;
   logic        data_wen_i;
   logic [31:0] data_wdata_i;
   logic [3:0]  data_be_i;
   logic [8:0]  data_ID_i;
   logic [7:0]  data_aux_i;
   logic        data_gnt_o;
   logic        data_r_valid_o;
   logic [31:0] data_r_rdata_o;
   logic [8:0]  data_r_ID_o;
   logic        data_r_opc_o;
   logic [7:0]  data_r_aux_o;
   logic        tgt_req_o;
   logic [31:0] tgt_add_o;
   logic        tgt_wen_o;
   logic [31:0] tgt_wdata_o;
   logic [3:0]  tgt_be_o;
   logic        tgt_gnt_i;
   logic        tgt_r_valid_i;
   logic [31:0] tgt_r_rdata_i;
   logic        tgt_r_opc_i;
   logic [2:0]  outstanding_o;
   logic        spurious_rsp_o;

   always #5 clk = ~clk;

   xbar_bridge_slave_port #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
      .ID_WIDTH(9), .AUX_WIDTH(8), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst(rst),
      .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
      .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
      .data_aux_i(data_aux_i), .data_gnt_o(data_gnt_o),
      .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o),
      .data_r_ID_o(data_r_ID_o), .data_r_opc_o(data_r_opc_o), .data_r_aux_o(data_r_aux_o),
      .tgt_req_o(tgt_req_o), .tgt_add_o(tgt_add_o), .tgt_wen_o(tgt_wen_o),
      .tgt_wdata_o(tgt_wdata_o), .tgt_be_o(tgt_be_o), .tgt_gnt_i(tgt_gnt_i),
      .tgt_r_valid_i(tgt_r_valid_i), .tgt_r_rdata_i(tgt_r_rdata_i),
      .tgt_r_opc_i(tgt_r_opc_i), .outstanding_o(outstanding_o),
      .spurious_rsp_o(spurious_rsp_o)
   );

   typedef struct packed {
      logic [8:0] id;
      logic [7:0] aux;
   } ent_t;

   typedef struct packed {
      logic        v;
      logic [8:0]  id;
      logic [7:0]  aux;
      logic [31:0] rd;
      logic        opc;
      logic        sp;
   } rsp_t;

   ent_t q[$];
   rsp_t e_reg = '0;
   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Response the spec's rules demand for the current inputs and tracked transactions
   function automatic rsp_t model_rsp();
      rsp_t r;
      r = '0;
      if (tgt_r_valid_i && q.size() > 0) begin
         r.v   = 1'b1;
         r.id  = q[0].id;
         r.aux = q[0].aux;
         r.rd  = tgt_r_rdata_i;
         r.opc = tgt_r_opc_i;
      end
      r.sp = tgt_r_valid_i && (q.size() == 0);
      return r;
   endfunction

   always @(posedge clk) begin
      bit acc;
      if (rst) begin
         q.delete();
         e_reg = '0;
      end else begin
         acc   = data_req_i && tgt_gnt_i && (q.size() != MAXO);
         e_reg = model_rsp();
         if (tgt_r_valid_i && q.size() > 0) void'(q.pop_front());
         if (acc) q.push_back('{id: data_ID_i, aux: data_aux_i});
      end
   end

   always @(negedge clk) begin
      rsp_t r;
      bit   full;
      if (chk_en) begin
         full = (q.size() == MAXO);
         chk("tgt_req", tgt_req_o, data_req_i && !full);
         chk("gnt", data_gnt_o, data_req_i && tgt_gnt_i && !full);
         chk("tgt_add", tgt_add_o, data_add_i);
         chk("tgt_wen", tgt_wen_o, data_wen_i);
         chk("tgt_wdata", tgt_wdata_o, data_wdata_i);
         chk("tgt_be", tgt_be_o, data_be_i);
         chk("outstanding", outstanding_o, q.size());
`ifdef XBRIDGE_SLV_RSP_REG_EN
         r = e_reg;
`else
         r = model_rsp();
`endif
         chk("r_valid", data_r_valid_o, r.v);
         chk("r_id", data_r_ID_o, r.id);
         chk("r_aux", data_r_aux_o, r.aux);
         chk("r_rdata", data_r_rdata_o, r.rd);
         chk("r_opc", data_r_opc_o, r.opc);
         chk("spurious", spurious_rsp_o, r.sp);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [8:0] id, input logic [7:0] aux);
      data_req_i = 1'b1; tgt_gnt_i = 1'b1;
      data_ID_i = id; data_aux_i = aux;
      data_add_i = {23'd0, id}; data_wdata_i = {24'd0, aux};
      step();
      data_req_i = 1'b0; tgt_gnt_i = 1'b0;
   endtask

   task automatic respond(input logic [31:0] rd);
      tgt_r_valid_i = 1'b1; tgt_r_rdata_i = rd;
      step();
      tgt_r_valid_i = 1'b0; tgt_r_rdata_i = '0;
   endtask

   initial begin
      rst = 1'b1; data_req_i = 1'b0; data_add_i = '0; data_wen_i = 1'b0;
      data_wdata_i = '0; data_be_i = 4'hF; data_ID_i = '0; data_aux_i = '0;
      tgt_gnt_i = 1'b0; tgt_r_valid_i = 1'b0; tgt_r_rdata_i = '0; tgt_r_opc_i = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("lit_rst_out", outstanding_o, 0);
      chk("lit_rst_rv", data_r_valid_o, 0);
      chk("lit_rst_sp", spurious_rsp_o, 0);
      step();

      // Single load, response two cycles after grant
      data_req_i = 1'b1; tgt_gnt_i = 1'b1; data_ID_i = 9'h004; data_aux_i = 8'h5A;
      data_wen_i = 1'b1; data_add_i = 32'h0000_1000;
      @(negedge clk);
      chk("lit_load_gnt", data_gnt_o, 1);
      step();
      data_req_i = 1'b0; tgt_gnt_i = 1'b0;
      @(negedge clk);
      chk("lit_load_out1", outstanding_o, 1);
      step();
      tgt_r_valid_i = 1'b1; tgt_r_rdata_i = 32'hDEADBEEF;
`ifndef XBRIDGE_SLV_RSP_REG_EN
      @(negedge clk);
      chk("lit_load_rv", data_r_valid_o, 1);
      chk("lit_load_id", data_r_ID_o, 9'h004);
      chk("lit_load_aux", data_r_aux_o, 8'h5A);
      chk("lit_load_rd", data_r_rdata_o, 32'hDEADBEEF);
`endif
      step();
      tgt_r_valid_i = 1'b0; tgt_r_rdata_i = '0;
      @(negedge clk);
`ifdef XBRIDGE_SLV_RSP_REG_EN
      chk("lit_load_rv", data_r_valid_o, 1);
      chk("lit_load_id", data_r_ID_o, 9'h004);
      chk("lit_load_aux", data_r_aux_o, 8'h5A);
      chk("lit_load_rd", data_r_rdata_o, 32'hDEADBEEF);
`endif
      chk("lit_load_out0", outstanding_o, 0);
      step();
      data_wen_i = 1'b0;

      // Fill the tracker, then drain in order
      for (int i = 0; i < 4; i++) accept(9'(1 << i), 8'(8'h10 + i));
      data_req_i = 1'b1; tgt_gnt_i = 1'b1; data_ID_i = 9'h010;
      @(negedge clk);
      chk("lit_full_gnt", data_gnt_o, 0);
      chk("lit_full_req", tgt_req_o, 0);
      chk("lit_full_out", outstanding_o, 4);
      step();
      data_req_i = 1'b0; tgt_gnt_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tgt_r_valid_i = 1'b1; tgt_r_rdata_i = 32'hA0 + i; tgt_r_opc_i = (i == 2);
`ifndef XBRIDGE_SLV_RSP_REG_EN
         @(negedge clk);
         chk("lit_fill_id", data_r_ID_o, 9'(1 << i));
`endif
         step();
      end
      tgt_r_valid_i = 1'b0; tgt_r_opc_i = 1'b0;
      step(); step();

      // Target stall for three cycles, then one grant
      data_req_i = 1'b1; data_ID_i = 9'h020; data_aux_i = 8'h33; tgt_gnt_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("lit_stall_gnt", data_gnt_o, 0);
         step();
      end
      tgt_gnt_i = 1'b1;
      @(negedge clk);
      chk("lit_stall_gnt4", data_gnt_o, 1);
      step();
      data_req_i = 1'b0; tgt_gnt_i = 1'b0;
      @(negedge clk);
      chk("lit_stall_out", outstanding_o, 1);
      step();
      respond(32'h5555_0000);
      step(); step();

      // Concurrent accept and pop at depth 2 across pointer wrap
      accept(9'h040, 8'hC0);
      accept(9'h080, 8'hC1);
      for (int k = 0; k < 10; k++) begin
         data_req_i = 1'b1; tgt_gnt_i = 1'b1;
         data_ID_i = 9'(k + 1); data_aux_i = 8'(k);
         tgt_r_valid_i = 1'b1; tgt_r_rdata_i = 32'(k);
         @(negedge clk);
         chk("lit_simul_out", outstanding_o, 2);
         step();
      end
      data_req_i = 1'b0; tgt_gnt_i = 1'b0;
      respond(32'h77);
      respond(32'h88);
      step();
      @(negedge clk);
      chk("lit_simul_drain", outstanding_o, 0);
      step();

      // Spurious response with an empty tracker
      tgt_r_valid_i = 1'b1; tgt_r_rdata_i = 32'h1234;
`ifndef XBRIDGE_SLV_RSP_REG_EN
      @(negedge clk);
      chk("lit_spur", spurious_rsp_o, 1);
      chk("lit_spur_rv", data_r_valid_o, 0);
`endif
      step();
      tgt_r_valid_i = 1'b0; tgt_r_rdata_i = '0;
      @(negedge clk);
`ifdef XBRIDGE_SLV_RSP_REG_EN
      chk("lit_spur", spurious_rsp_o, 1);
      chk("lit_spur_rv", data_r_valid_o, 0);
`endif
      chk("lit_spur_out", outstanding_o, 0);
      step();

      // Reset with three outstanding, then normal operation
      accept(9'h001, 8'hE0);
      accept(9'h002, 8'hE1);
      accept(9'h004, 8'hE2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("lit_rst3_out", outstanding_o, 0);
      chk("lit_rst3_rv", data_r_valid_o, 0);
      step();
      data_req_i = 1'b1; tgt_gnt_i = 1'b1; data_ID_i = 9'h100; data_aux_i = 8'hF0;
      @(negedge clk);
      chk("lit_post_rst_gnt", data_gnt_o, 1);
      step();
      data_req_i = 1'b0; tgt_gnt_i = 1'b0;
      step();
      respond(32'hCAFE_F00D);
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/xbar_bridge_slave_port.md
# xbar_bridge_slave_port

Slave-side endpoint for one `N_SLAVE` port of the crossbar bridge. It accepts ID-tagged requests from the bridge and forwards them to a single in-order target, such as an SRAM or peripheral, that has a req/gnt handshake with variable latency. It tracks up to `MAX_OUTSTANDING` transactions in an ID/AUX FIFO and returns each target response to the bridge with the matching `data_r_ID_o` and `data_r_aux_o`, so the bridge can back-route it to the originating master.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, request address width.
- `DATA_WIDTH`, 32, data width.
- `BE_WIDTH`, `DATA_WIDTH/8`, byte-enable width.
- `ID_WIDTH`, 9, one-hot master ID width (`N_CH0+N_CH1`).
- `AUX_WIDTH`, 8, AUX sideband width.
- `MAX_OUTSTANDING`, 4, tracker depth; must be a power of 2 and ≥2.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `data_req_i`  in  1  request from bridge.
- `data_add_i`  in  `ADDR_WIDTH`  address.
- `data_wen_i`  in  1  0=store, 1=load.
- `data_wdata_i`  in  `DATA_WIDTH`  write data.
- `data_be_i`  in  `BE_WIDTH`  byte enable.
- `data_ID_i`  in  `ID_WIDTH`  master ID.
- `data_aux_i`  in  `AUX_WIDTH`  AUX.
- `data_gnt_o`  out  1  grant to bridge.
- `data_r_valid_o`  out  1  response valid.
- `data_r_rdata_o`  out  `DATA_WIDTH`  response data.
- `data_r_ID_o`  out  `ID_WIDTH`  response ID.
- `data_r_opc_o`  out  1  response error.
- `data_r_aux_o`  out  `AUX_WIDTH`  response AUX.
- `tgt_req_o`  out  1  target request.
- `tgt_add_o`  out  `ADDR_WIDTH`  target address, pass-through.
- `tgt_wen_o`  out  1  target wen, pass-through.
- `tgt_wdata_o`  out  `DATA_WIDTH`  target wdata, pass-through.
- `tgt_be_o`  out  `BE_WIDTH`  target be, pass-through.
- `tgt_gnt_i`  in  1  target grant.
- `tgt_r_valid_i`  in  1  target response valid; in order, no backpressure.
- `tgt_r_rdata_i`  in  `DATA_WIDTH`  target read data.
- `tgt_r_opc_i`  in  1  target error.
- `outstanding_o`  out  `$clog2(MAX_OUTSTANDING)+1`  live transaction count.
- `spurious_rsp_o`  out  1  one-cycle pulse on a response received with the tracker empty.

## Operation
- `full = (outstanding_o == MAX_OUTSTANDING)`. A pop in the same cycle does not clear `full` for that cycle, so there is no `tgt_r_valid_i`→`data_gnt_o` combinational path.
- Request path:
  - `tgt_req_o = data_req_i & ~full`.
  - `data_gnt_o = data_req_i & tgt_gnt_i & ~full`.
  - Address, wen, wdata and be pass through combinationally.
- Accept (`data_req_i & data_gnt_o`): push {`data_ID_i`, `data_aux_i`} into the tracker FIFO and increment the count.
- Response (`tgt_r_valid_i` with FIFO non-empty):
  - Pop the head and decrement the count.
  - Drive `data_r_valid_o=1`, `data_r_ID_o`/`data_r_aux_o` = popped head, `data_r_rdata_o = tgt_r_rdata_i`, `data_r_opc_o = tgt_r_opc_i`.
  - Stores also receive a response; `rdata` is passed through unchanged.
- Simultaneous accept and pop: the count is unchanged and both pointers advance. The target never responds in its grant cycle.
- `tgt_r_valid_i` with FIFO empty: the response is dropped, `data_r_valid_o` stays 0, the count stays 0, and `spurious_rsp_o` pulses.
- When `data_r_valid_o=0`, all `data_r_*` payload outputs are driven to 0.
- Pointers are `$clog2(MAX_OUTSTANDING)` bits wide and wrap naturally. The count saturates by construction and never exceeds `MAX_OUTSTANDING`.

## Timing
- Reset values: pointers 0, count 0, `spurious_rsp_o` 0, `data_r_valid_o` 0, all `data_r_*` 0.
- Reset asserted mid-operation flushes the tracker. Target responses still in flight are then treated as spurious after reset deasserts; the integrator must reset the target together with this block.
- Grant: zero-cycle, combinational from `tgt_gnt_i`.
- Response latency: 0 cycles from `tgt_r_valid_i` by default; 1 cycle when `XBRIDGE_SLV_RSP_REG_EN` is defined.
- `outstanding_o` updates on the clock edge following the accept or pop.

## Configuration
- `XBRIDGE_SLV_RSP_REG_EN` defined:
  - All `data_r_*` outputs and `spurious_rsp_o` are registered, adding 1 cycle.
  - The FIFO pop and count decrement still occur in the `tgt_r_valid_i` cycle.
  - Back-to-back responses produce back-to-back `data_r_valid_o` pulses.
- Not defined: the response path is combinational as described above.

## Test plan
- Single load: ID=9'h004, AUX=8'h5A, target grants immediately and responds 2 cycles later with rdata 32'hDEADBEEF, opc=0 -> one `data_r_valid_o` pulse carrying ID 9'h004, AUX 8'h5A, rdata DEADBEEF; `outstanding_o` goes 1 then 0.
- Fill: 4 grants with IDs 001, 002, 004, 008 and no responses -> 5th request sees `data_gnt_o=0`, `tgt_req_o=0`, `outstanding_o=4`; then 4 in-order responses -> IDs returned as 001, 002, 004, 008.
- Target stall: `tgt_gnt_i=0` for 3 cycles while `data_req_i=1` -> `data_gnt_o=0` for those cycles, no push; grant on cycle 4 -> exactly one push.
- Simultaneous accept and pop at count=2 -> count stays 2; response carries the oldest ID; sustained for 10 cycles across pointer wrap with no ID reordering.
- Spurious response: `tgt_r_valid_i=1` with empty tracker -> `spurious_rsp_o=1` for 1 cycle, `data_r_valid_o=0`, `outstanding_o=0`.
- Reset with 3 outstanding: assert `rst` for 1 cycle -> `outstanding_o=0`, `data_r_valid_o=0`; the next request is accepted normally. Repeat the whole suite with `XBRIDGE_SLV_RSP_REG_EN` and check the +1-cycle response latency.
